// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and sizing helpers for the iterative adder/subtractor.
`default_nettype none

package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single chunk still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_iter_cond_invert.sv
// cond_invert: conditional one's complement of the B operand (XOR with the subtract control).
`default_nettype none

module cond_invert #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] res
);

  assign res = b ^ {WIDTH{s}};

endmodule

`default_nettype wire

// File: rtl/addsub_iter.sv
// addsub_iter: multi-cycle adder/subtractor summing CHUNK bits per cycle, with ALU flags
// and a start/busy/done handshake.
`default_nettype none

module addsub_iter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;

  logic [WIDTH-1:0] b_inv;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

  cond_invert #(.WIDTH(WIDTH)) u_inv (
    .b   (b),
    .s   (sub),
    .res (b_inv)
  );

  always_comb begin
    a_chunk   = CHUNK'(a_q >> (int'(idx) * CHUNK));
    b_chunk   = CHUNK'(b_q >> (int'(idx) * CHUNK));
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b_inv;
            cy_q  <= sub;  // subtraction is A + ~B + 1
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[int'(idx) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cy_q <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ST_FIN;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_FIN: begin
          res      <= sum_q;
          carry    <= cy_q;
          overflow <= (a_q[MSB] == b_q[MSB]) && (sum_q[MSB] != a_q[MSB]);
          zero     <= (sum_q == '0);
          neg      <= sum_q[MSB];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
